// File: rtl/vram_mc.sv
// Multi-bank video RAM controller: one byte-enabled 32-bit CPU port and VID_CH
// 16-bit video read channels over word-interleaved, single-access banks.
module vram_mc #(
    parameter int ADDR_W     = 12,
    parameter int NUM_BANKS  = 2,
    parameter int VID_CH     = 2,
    parameter int STARVE_MAX = 7
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cpu_req,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic                         cpu_wren,
    input  logic [3:0]                   cpu_bytesel,
    input  logic [31:0]                  cpu_wrdata,
    output logic                         cpu_ack,
    output logic                         cpu_rdvalid,
    output logic [31:0]                  cpu_rddata,
    input  logic [VID_CH-1:0]            vid_req,
    input  logic [VID_CH*(ADDR_W+1)-1:0] vid_addr,
    output logic [VID_CH-1:0]            vid_ack,
    output logic [VID_CH-1:0]            vid_rdvalid,
    output logic [VID_CH*16-1:0]         vid_rddata
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BK_W      = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_W     = ADDR_W - BANK_BITS;
    localparam int ROWS      = 1 << ROW_W;

    logic [31:0] mem [NUM_BANKS][ROWS];

    function automatic logic [BK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
        if (NUM_BANKS == 1) return '0;
        return a[BK_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: ROW_W];
    endfunction

    logic [BK_W-1:0]                cpu_bank;
    logic [ROW_W-1:0]               cpu_row;
    logic [VID_CH-1:0][ADDR_W-1:0]  vid_word;
    logic [VID_CH-1:0][BK_W-1:0]    vid_bank;
    logic [VID_CH-1:0][ROW_W-1:0]   vid_row;
    logic [VID_CH-1:0]              vid_hsel;
    logic                           force_cpu;
    logic                           cpu_blocked;

    logic [7:0]                     starve_q, starve_d;
    logic                           cpu_rdvalid_q, cpu_rdvalid_d;
    logic [31:0]                    cpu_rddata_q, cpu_rddata_d;
    logic [VID_CH-1:0]              vid_rdvalid_q, vid_rdvalid_d;
    logic [VID_CH-1:0][31:0]        vid_word_q, vid_word_d;
    logic [VID_CH-1:0]              vid_hsel_q, vid_hsel_d;

    always_comb begin
        cpu_bank = bank_of(cpu_addr);
        cpu_row  = row_of(cpu_addr);
        for (int c = 0; c < VID_CH; c++) begin
            vid_word[c] = vid_addr[c*(ADDR_W+1)+1 +: ADDR_W];
            vid_hsel[c] = vid_addr[c*(ADDR_W+1)];
            vid_bank[c] = bank_of(vid_word[c]);
            vid_row[c]  = row_of(vid_word[c]);
        end
    end

    // Per-bank arbitration: lowest video channel wins unless the CPU has waited too long.
    always_comb begin
        force_cpu   = cpu_req && (starve_q == 8'(STARVE_MAX));
        cpu_blocked = 1'b0;
        vid_ack     = '0;
        for (int c = 0; c < VID_CH; c++) begin
            vid_ack[c] = vid_req[c] && reset_n && !(force_cpu && (vid_bank[c] == cpu_bank));
            for (int p = 0; p < c; p++) begin
                if (vid_req[p] && (vid_bank[p] == vid_bank[c])) vid_ack[c] = 1'b0;
            end
            if (vid_req[c] && (vid_bank[c] == cpu_bank)) cpu_blocked = 1'b1;
        end
        cpu_ack = cpu_req && reset_n && (force_cpu || !cpu_blocked);
    end

    always_comb begin
        starve_d      = (cpu_req && !cpu_ack) ? starve_q + 8'd1 : 8'd0;
        cpu_rdvalid_d = cpu_ack && !cpu_wren;
        cpu_rddata_d  = cpu_rdvalid_d ? mem[cpu_bank][cpu_row] : cpu_rddata_q;
        vid_rdvalid_d = vid_ack;
        for (int c = 0; c < VID_CH; c++) begin
            vid_word_d[c] = vid_ack[c] ? mem[vid_bank[c]][vid_row[c]] : vid_word_q[c];
            vid_hsel_d[c] = vid_ack[c] ? vid_hsel[c] : vid_hsel_q[c];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q      <= '0;
            cpu_rdvalid_q <= 1'b0;
            cpu_rddata_q  <= '0;
            vid_rdvalid_q <= '0;
            vid_word_q    <= '0;
            vid_hsel_q    <= '0;
        end else begin
            starve_q      <= starve_d;
            cpu_rdvalid_q <= cpu_rdvalid_d;
            cpu_rddata_q  <= cpu_rddata_d;
            vid_rdvalid_q <= vid_rdvalid_d;
            vid_word_q    <= vid_word_d;
            vid_hsel_q    <= vid_hsel_d;
        end
    end

    // RAM contents survive reset; only the CPU ever writes.
    always_ff @(posedge clk) begin
        if (cpu_ack && cpu_wren) begin
            for (int i = 0; i < 4; i++) begin
                if (cpu_bytesel[i]) mem[cpu_bank][cpu_row][8*i +: 8] <= cpu_wrdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < VID_CH; c++) begin
            vid_rddata[c*16 +: 16] = vid_hsel_q[c] ? vid_word_q[c][31:16] : vid_word_q[c][15:0];
        end
    end

    assign cpu_rdvalid = cpu_rdvalid_q;
    assign cpu_rddata  = cpu_rddata_q;
    assign vid_rdvalid = vid_rdvalid_q;

endmodule

// File: tb/tb_vram_mc.sv
// Testbench for vram_mc: directed scenarios plus randomized traffic against a
// behavioural bank-claim model of the RAM and its arbitration.
module tb_vram_mc;
    localparam int AW = 12;
    localparam int NB = 2;
    localparam int VC = 2;
    localparam int SM = 7;
    localparam int HW = AW + 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cpu_req;
    logic [AW-1:0]     cpu_addr;
    logic              cpu_wren;
    logic [3:0]        cpu_bytesel;
    logic [31:0]       cpu_wrdata;
    logic              cpu_ack;
    logic              cpu_rdvalid;
    logic [31:0]       cpu_rddata;
    logic [VC-1:0]     vid_req;
    logic [VC*HW-1:0]  vid_addr;
    logic [VC-1:0]     vid_ack;
    logic [VC-1:0]     vid_rdvalid;
    logic [VC*16-1:0]  vid_rddata;

    vram_mc #(.ADDR_W(AW), .NUM_BANKS(NB), .VID_CH(VC), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
        .cpu_bytesel(cpu_bytesel), .cpu_wrdata(cpu_wrdata),
        .cpu_ack(cpu_ack), .cpu_rdvalid(cpu_rdvalid), .cpu_rddata(cpu_rddata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rdvalid(vid_rdvalid), .vid_rddata(vid_rddata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0]      ref_mem [0:(1<<AW)-1];
    int               m_wait;
    logic             exp_cpu_ack;
    logic [VC-1:0]    exp_vid_ack;
    logic             exp_cpu_rdvalid, nxt_cpu_rdvalid;
    logic [31:0]      exp_cpu_rddata, nxt_cpu_rddata;
    logic [VC-1:0]    exp_vid_rdvalid, nxt_vid_rdvalid;
    logic [VC*16-1:0] exp_vid_rddata, nxt_vid_rddata;
    logic             obs_cpu_ack;
    logic [VC-1:0]    obs_vid_ack;

    task automatic model_reset();
        m_wait          = 0;
        exp_cpu_rdvalid = 1'b0;
        exp_cpu_rddata  = '0;
        exp_vid_rdvalid = '0;
        exp_vid_rddata  = '0;
    endtask

    // Each bank is claimed by whoever gets first pick: a starved CPU, then channels by priority.
    task automatic model_comb();
        bit claimed [NB];
        bit forced;
        int cb, w, b;
        logic [HW-1:0] ha;
        for (int i = 0; i < NB; i++) claimed[i] = 1'b0;
        nxt_cpu_rdvalid = 1'b0;
        nxt_cpu_rddata  = exp_cpu_rddata;
        nxt_vid_rdvalid = '0;
        nxt_vid_rddata  = exp_vid_rddata;
        cb     = int'(cpu_addr) % NB;
        forced = cpu_req && (m_wait == SM);
        if (forced) claimed[cb] = 1'b1;
        exp_vid_ack = '0;
        for (int c = 0; c < VC; c++) begin
            if (vid_req[c]) begin
                ha = vid_addr[c*HW +: HW];
                w  = int'(ha) / 2;
                b  = w % NB;
                if (!claimed[b]) begin
                    exp_vid_ack[c]     = 1'b1;
                    nxt_vid_rdvalid[c] = 1'b1;
                    nxt_vid_rddata[c*16 +: 16] = ha[0] ? ref_mem[w][31:16] : ref_mem[w][15:0];
                end
                claimed[b] = 1'b1;
            end
        end
        exp_cpu_ack = cpu_req && (forced || !claimed[cb]);
        if (exp_cpu_ack && cpu_wren) begin
            for (int i = 0; i < 4; i++)
                if (cpu_bytesel[i]) ref_mem[int'(cpu_addr)][8*i +: 8] = cpu_wrdata[8*i +: 8];
        end else if (exp_cpu_ack) begin
            nxt_cpu_rdvalid = 1'b1;
            nxt_cpu_rddata  = ref_mem[int'(cpu_addr)];
        end
        m_wait = (cpu_req && !exp_cpu_ack) ? m_wait + 1 : 0;
    endtask

    task automatic model_seq();
        exp_cpu_rdvalid = nxt_cpu_rdvalid;
        exp_cpu_rddata  = nxt_cpu_rddata;
        exp_vid_rdvalid = nxt_vid_rdvalid;
        exp_vid_rddata  = nxt_vid_rddata;
    endtask

    // One clock: acks captured mid-cycle, registered outputs valid on return (#1 after edge).
    task automatic tick();
        @(negedge clk);
        obs_cpu_ack = cpu_ack;
        obs_vid_ack = vid_ack;
        model_comb();
        @(posedge clk);
        #1;
        model_seq();
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_addr = '0; cpu_wren = 1'b0; cpu_bytesel = '0; cpu_wrdata = '0;
        vid_req = '0; vid_addr = '0;
    endtask

    task automatic set_vid(input int c, input int ha, input bit req);
        vid_req[c] = req;
        vid_addr[c*HW +: HW] = HW'(ha);
    endtask

    task automatic cpu_set(input int addr, input bit wr, input logic [3:0] be, input logic [31:0] d);
        cpu_req = 1'b1; cpu_addr = AW'(addr); cpu_wren = wr; cpu_bytesel = be; cpu_wrdata = d;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        cpu_set(3, 1'b0, 4'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (cpu_ack !== 1'b0) begin n_errors++; $display("FAIL rst_cpu_ack: got %b want 0", cpu_ack); end
        n_checks++; if (cpu_rdvalid !== 1'b0) begin n_errors++; $display("FAIL rst_cpu_rdvalid: got %b want 0", cpu_rdvalid); end
        n_checks++; if (cpu_rddata !== 32'h0) begin n_errors++; $display("FAIL rst_cpu_rddata: got %h want 0", cpu_rddata); end
        n_checks++; if (vid_rdvalid !== '0) begin n_errors++; $display("FAIL rst_vid_rdvalid: got %b want 0", vid_rdvalid); end
        n_checks++; if (vid_rddata !== '0) begin n_errors++; $display("FAIL rst_vid_rddata: got %h want 0", vid_rddata); end
        idle();
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_init();
        for (int w = 0; w < 32; w++) begin
            cpu_set(w, 1'b1, 4'hF, $urandom);
            tick();
            n_checks++; if (obs_cpu_ack !== 1'b1) begin n_errors++; $display("FAIL init_ack[%0d]: got %b want 1", w, obs_cpu_ack); end
        end
        idle();
    endtask

    task automatic test_write_read();
        idle();
        cpu_set(5, 1'b1, 4'hF, 32'hDEADBEEF);
        tick();
        n_checks++; if (obs_cpu_ack !== 1'b1) begin n_errors++; $display("FAIL wr_ack: got %b want 1", obs_cpu_ack); end
        n_checks++; if (cpu_rdvalid !== 1'b0) begin n_errors++; $display("FAIL wr_no_rdvalid: got %b want 0", cpu_rdvalid); end
        cpu_set(5, 1'b0, 4'h0, 32'h0);
        tick();
        n_checks++; if (obs_cpu_ack !== 1'b1) begin n_errors++; $display("FAIL rd_ack: got %b want 1", obs_cpu_ack); end
        n_checks++; if (cpu_rdvalid !== 1'b1) begin n_errors++; $display("FAIL rd_rdvalid: got %b want 1", cpu_rdvalid); end
        n_checks++; if (cpu_rddata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_data: got %h want deadbeef", cpu_rddata); end
        idle();
        tick();
        n_checks++; if (cpu_rddata !== 32'hDEADBEEF || cpu_rdvalid !== 1'b0) begin n_errors++; $display("FAIL rd_hold: got %h/%b want deadbeef/0", cpu_rddata, cpu_rdvalid); end
    endtask

    task automatic test_byte_write();
        idle();
        cpu_set(5, 1'b1, 4'b0001, 32'h000000AA);
        tick();
        idle();
        set_vid(0, 10, 1'b1);
        tick();
        n_checks++; if (obs_vid_ack[0] !== 1'b1) begin n_errors++; $display("FAIL bw_ack_lo: got %b want 1", obs_vid_ack[0]); end
        n_checks++; if (vid_rddata[15:0] !== 16'hBEAA) begin n_errors++; $display("FAIL bw_lo: got %h want beaa", vid_rddata[15:0]); end
        set_vid(0, 11, 1'b1);
        tick();
        n_checks++; if (vid_rddata[15:0] !== 16'hDEAD || vid_rdvalid[0] !== 1'b1) begin n_errors++; $display("FAIL bw_hi: got %h/%b want dead/1", vid_rddata[15:0], vid_rdvalid[0]); end
        idle();
    endtask

    task automatic test_banks();
        idle();
        set_vid(0, 8, 1'b1);
        set_vid(1, 14, 1'b1);
        tick();
        n_checks++; if (obs_vid_ack !== 2'b11) begin n_errors++; $display("FAIL bank_par_ack: got %b want 11", obs_vid_ack); end
        n_checks++; if (vid_rdvalid !== 2'b11) begin n_errors++; $display("FAIL bank_par_rdvalid: got %b want 11", vid_rdvalid); end
        n_checks++; if (vid_rddata !== {ref_mem[7][15:0], ref_mem[4][15:0]}) begin n_errors++; $display("FAIL bank_par_data: got %h want %h", vid_rddata, {ref_mem[7][15:0], ref_mem[4][15:0]}); end
        set_vid(1, 0, 1'b1);
        tick();
        n_checks++; if (obs_vid_ack !== 2'b01) begin n_errors++; $display("FAIL bank_conf_ack: got %b want 01", obs_vid_ack); end
        set_vid(0, 8, 1'b0);
        tick();
        n_checks++; if (obs_vid_ack !== 2'b10) begin n_errors++; $display("FAIL bank_conf_ack2: got %b want 10", obs_vid_ack); end
        n_checks++; if (vid_rddata[31:16] !== ref_mem[0][15:0]) begin n_errors++; $display("FAIL bank_conf_data: got %h want %h", vid_rddata[31:16], ref_mem[0][15:0]); end
        idle();
    endtask

    task automatic test_starve();
        idle();
        tick();
        set_vid(0, 4, 1'b1);
        cpu_set(0, 1'b0, 4'h0, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++; if (obs_cpu_ack !== (i == 8)) begin n_errors++; $display("FAIL starve_cpu_ack[%0d]: got %b want %b", i, obs_cpu_ack, (i == 8)); end
            n_checks++; if (obs_vid_ack[0] !== (i != 8)) begin n_errors++; $display("FAIL starve_vid_ack[%0d]: got %b want %b", i, obs_vid_ack[0], (i != 8)); end
        end
        n_checks++; if (cpu_rdvalid !== 1'b1 || cpu_rddata !== ref_mem[0]) begin n_errors++; $display("FAIL starve_data: got %h/%b want %h/1", cpu_rddata, cpu_rdvalid, ref_mem[0]); end
        cpu_req = 1'b0;
        tick();
        n_checks++; if (obs_vid_ack[0] !== 1'b1) begin n_errors++; $display("FAIL starve_vid_resume: got %b want 1", obs_vid_ack[0]); end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        cpu_set(5, 1'b0, 4'h0, 32'h0);
        set_vid(0, 8, 1'b1);
        tick();
        n_checks++; if (cpu_rdvalid !== 1'b1 || vid_rdvalid[0] !== 1'b1) begin n_errors++; $display("FAIL rmid_pre: got %b/%b want 1/1", cpu_rdvalid, vid_rdvalid[0]); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (cpu_rdvalid !== 1'b0 || vid_rdvalid !== '0) begin n_errors++; $display("FAIL rmid_rdvalid: got %b/%b want 0/0", cpu_rdvalid, vid_rdvalid); end
        n_checks++; if (cpu_rddata !== '0 || vid_rddata !== '0) begin n_errors++; $display("FAIL rmid_rddata: got %h/%h want 0/0", cpu_rddata, vid_rddata); end
        n_checks++; if (cpu_ack !== 1'b0) begin n_errors++; $display("FAIL rmid_ack: got %b want 0", cpu_ack); end
        idle();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        cpu_set(5, 1'b0, 4'h0, 32'h0);
        tick();
        n_checks++; if (cpu_rddata !== 32'hDEADBEAA || cpu_rdvalid !== 1'b1) begin n_errors++; $display("FAIL rmid_retained: got %h/%b want deadbeaa/1", cpu_rddata, cpu_rdvalid); end
        idle();
    endtask

    task automatic test_write_then_read();
        logic [31:0] d;
        d = $urandom;
        idle();
        cpu_set(9, 1'b1, 4'hF, d);
        tick();
        n_checks++; if (obs_cpu_ack !== 1'b1) begin n_errors++; $display("FAIL wtr_ack: got %b want 1", obs_cpu_ack); end
        idle();
        set_vid(1, 18, 1'b1);
        tick();
        n_checks++; if (obs_vid_ack[1] !== 1'b1) begin n_errors++; $display("FAIL wtr_vid_ack: got %b want 1", obs_vid_ack[1]); end
        n_checks++; if (vid_rddata[31:16] !== d[15:0]) begin n_errors++; $display("FAIL wtr_data: got %h want %h", vid_rddata[31:16], d[15:0]); end
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 0; i < 8; i++) begin
            set_vid(0, 2 * i + (i % 2), 1'b1);
            tick();
            n_checks++; if (obs_vid_ack[0] !== 1'b1) begin n_errors++; $display("FAIL b2b_ack[%0d]: got %b want 1", i, obs_vid_ack[0]); end
            n_checks++; if (vid_rdvalid[0] !== 1'b1 || vid_rddata[15:0] !== exp_vid_rddata[15:0]) begin n_errors++; $display("FAIL b2b_data[%0d]: got %h/%b want %h/1", i, vid_rddata[15:0], vid_rdvalid[0], exp_vid_rddata[15:0]); end
        end
        idle();
    endtask

    task automatic test_random();
        bit pend = 1'b0;
        idle();
        for (int n = 0; n < 500; n++) begin
            if (!pend) begin
                if ($urandom_range(0, 2) != 0) begin
                    cpu_set(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
                    pend = 1'b1;
                end else begin
                    cpu_req = 1'b0;
                end
            end
            for (int c = 0; c < VC; c++) set_vid(c, int'($urandom_range(0, 63)), ($urandom_range(0, 3) != 0));
            tick();
            n_checks++; if (obs_cpu_ack !== exp_cpu_ack) begin n_errors++; $display("FAIL rnd_cpu_ack[%0d]: got %b want %b", n, obs_cpu_ack, exp_cpu_ack); end
            n_checks++; if (obs_vid_ack !== exp_vid_ack) begin n_errors++; $display("FAIL rnd_vid_ack[%0d]: got %b want %b", n, obs_vid_ack, exp_vid_ack); end
            n_checks++; if (cpu_rdvalid !== exp_cpu_rdvalid) begin n_errors++; $display("FAIL rnd_cpu_rdvalid[%0d]: got %b want %b", n, cpu_rdvalid, exp_cpu_rdvalid); end
            n_checks++; if (cpu_rddata !== exp_cpu_rddata) begin n_errors++; $display("FAIL rnd_cpu_rddata[%0d]: got %h want %h", n, cpu_rddata, exp_cpu_rddata); end
            n_checks++; if (vid_rdvalid !== exp_vid_rdvalid) begin n_errors++; $display("FAIL rnd_vid_rdvalid[%0d]: got %b want %b", n, vid_rdvalid, exp_vid_rdvalid); end
            n_checks++; if (vid_rddata !== exp_vid_rddata) begin n_errors++; $display("FAIL rnd_vid_rddata[%0d]: got %h want %h", n, vid_rddata, exp_vid_rddata); end
            if (obs_cpu_ack) pend = 1'b0;
        end
        idle();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        test_reset();
        test_init();
        test_write_read();
        test_byte_write();
        test_banks();
        test_starve();
        test_reset_mid();
        test_write_then_read();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
